// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the BRAM block-read streamer.
package bram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    // Output buffer depth; the issue throttle keeps occupancy plus in-flight reads within it.
    localparam int READER_FIFO_DEPTH = 2;

endpackage

// File: rtl/reader_fifo2.sv
// Two-entry synchronous FIFO whose head entry is a register driving the stream outputs directly.
module reader_fifo2 #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             valid,
    output logic [1:0]       count
);

    logic [width-1:0] tail;

    assign valid = (count != 2'd0);

    // Head/tail shuffle; head only changes on a pop or when it is empty, so it holds during stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (push && pop) begin
            if (count == 2'd2) begin
                head <= tail;
                tail <= din;
            end else begin
                head <= din;
            end
        end else if (pop) begin
            head  <= tail;
            count <= count - 2'd1;
        end else if (push) begin
            if (count == 2'd0) begin
                head <= din;
            end else begin
                tail <= din;
            end
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a contiguous bram_sp address range and presents the words as a valid/ready stream.
module bram_stream_reader
    import bram_reader_pkg::*;
#(
    parameter int data_width    = 72,
    parameter int address_width = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [address_width-1:0] start_addr,
    input  logic [address_width:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic [address_width-1:0] ram_addr,
    output logic                     ram_wr,
    input  logic [data_width-1:0]    ram_dout,
    output logic [data_width-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last
);

    reader_state_t          state, state_next;
    logic [address_width:0] remaining;
    logic                   inflight, inflight_last;
    logic                   accept, issue, last_issue, done_next;
    logic                   pop;
    logic [2:0]             pending;
    logic [1:0]             fifo_count;
    logic [data_width:0]    fifo_head;

    assign ram_wr  = 1'b0;
    assign busy    = (state != IDLE);
    assign m_data  = fifo_head[data_width-1:0];
    assign m_last  = fifo_head[data_width];
    assign pop     = m_valid & m_ready;
    // Words that will occupy the FIFO after this cycle, before any new issue.
    assign pending = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    reader_fifo2 #(
        .width(data_width + 1)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (inflight),
        .din  ({inflight_last, ram_dout}),
        .pop  (pop),
        .head (fifo_head),
        .valid(m_valid),
        .count(fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, command acceptance and read-issue decisions.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        last_issue = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (pending < 3'(READER_FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (remaining == (address_width+1)'(1)) begin
                        last_issue = 1'b1;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address/remaining counters, one-deep in-flight tracker and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= done_next;
            inflight      <= issue;
            inflight_last <= last_issue;
            if (accept) begin
                ram_addr  <= start_addr;
                remaining <= length;
            end else if (issue) begin
                ram_addr  <= ram_addr + address_width'(1);
                remaining <= remaining - (address_width+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural bram_sp read port.
module tb_bram_stream_reader;

    localparam int DW = 72;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy, done, ram_wr, m_valid, m_ready, m_last;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout, m_data;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW:0]   len;
        int            mode;   // 0: ready=1, 1: random ready, 2: ready=1 plus ignored start
        logic [DW-1:0] first;
        logic [DW-1:0] last;
    } cmd_t;

    cmd_t vec [0:5];

    bram_stream_reader #(.data_width(DW), .address_width(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .length(length), .busy(busy), .done(done), .ram_addr(ram_addr),
        .ram_wr(ram_wr), .ram_dout(ram_dout), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // bram_sp read port: one-cycle registered read.
    always @(posedge clk) ram_dout <= mem[ram_addr];

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, " busy"},     busy,     0);
        check({tag, " done"},     done,     0);
        check({tag, " ram_addr"}, ram_addr, 0);
        check({tag, " ram_wr"},   ram_wr,   0);
        check({tag, " m_data"},   m_data,   0);
        check({tag, " m_valid"},  m_valid,  0);
        check({tag, " m_last"},   m_last,   0);
    endtask

    // Issues a command in the current cycle and returns in the cycle where done is expected.
    task automatic run_cmd(input cmd_t c, input int id);
        int            cyc = 0, beats = 0, first_cyc = -1, done_early = 0, ovf = 0, wr_seen = 0;
        logic          stall = 1'b0, held_last = 1'b0;
        logic [DW-1:0] held_data = '0, exp_data;
        logic [AW-1:0] a;
        start_addr = c.addr;
        length     = c.len;
        while (beats < int'(c.len) && cyc < 3000) begin
            start = (cyc == 0) || (c.mode == 2 && cyc == 2);
            if (cyc == 2 && c.mode == 2) begin
                start_addr = c.addr + 10'd77;
                length     = 11'd3;
            end
            m_ready = (c.mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (cyc == 1) begin
                check($sformatf("cmd%0d busy at cycle 1", id), busy, 1);
                check($sformatf("cmd%0d ram_addr at cycle 1", id), ram_addr, c.addr);
            end
            if (stall) begin
                check($sformatf("cmd%0d stall hold", id), {m_valid, m_last, m_data},
                      {1'b1, held_last, held_data});
            end
            if (cyc >= 1 && done) done_early++;
            if (dut.u_fifo.count > 2'd2) ovf++;
            if (ram_wr !== 1'b0) wr_seen++;
            if (m_valid && m_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                a        = c.addr + AW'(beats);
                exp_data = {{(DW-AW){1'b0}}, a} + 72'h100;
                check($sformatf("cmd%0d beat%0d data", id, beats), m_data, exp_data);
                check($sformatf("cmd%0d beat%0d last", id, beats), m_last, beats == int'(c.len) - 1);
                if (beats == 0) check($sformatf("cmd%0d first word", id), m_data, c.first);
                if (beats == int'(c.len) - 1) check($sformatf("cmd%0d last word", id), m_data, c.last);
                beats++;
            end
            stall     = m_valid && !m_ready;
            held_data = m_data;
            held_last = m_last;
            tick();
            cyc++;
        end
        start   = 1'b0;
        m_ready = 1'b0;
        check($sformatf("cmd%0d beat count", id), beats, c.len);
        check($sformatf("cmd%0d done pulse", id), done, 1);
        check($sformatf("cmd%0d busy at done", id), busy, 0);
        check($sformatf("cmd%0d valid at done", id), m_valid, 0);
        check($sformatf("cmd%0d early done", id), done_early, 0);
        check($sformatf("cmd%0d fifo overflow", id), ovf, 0);
        check($sformatf("cmd%0d ram_wr", id), wr_seen, 0);
        if (c.mode != 1) check($sformatf("cmd%0d first valid cycle", id), first_cyc, 3);
    endtask

    initial begin
        cmd_t tmp;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 'h100);
        reset = 1'b1; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        vec[0] = '{10'd5,    11'd4,    0, 72'h105, 72'h108};
        vec[1] = '{10'd100,  11'd8,    1, 72'h164, 72'h16b};
        vec[2] = '{10'd1022, 11'd4,    0, 72'h4fe, 72'h101};
        vec[3] = '{10'd1023, 11'd2,    1, 72'h4ff, 72'h100};
        vec[4] = '{10'd0,    11'd1024, 0, 72'h100, 72'h4ff};
        vec[5] = '{10'd200,  11'd6,    2, 72'h1c8, 72'h1cd};
        for (int i = 0; i < 6; i++) begin
            run_cmd(vec[i], i);
            tick();
            check($sformatf("cmd%0d done width", i), done, 0);
        end

        // Zero-length command: done next cycle, no beats, never busy.
        start = 1'b1; start_addr = 10'd7; length = 11'd0;
        tick();
        start = 1'b0;
        check("zero done", done, 1);
        check("zero busy", busy, 0);
        check("zero valid", m_valid, 0);
        tick();
        check("zero done after", done, 0);
        check("zero busy after", busy, 0);
        tick();
        check("zero valid later", m_valid, 0);

        // Reset after two beats of a six-beat command.
        start = 1'b1; start_addr = 10'd300; length = 11'd6; m_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midreset beat0", m_data, 72'h22c);
        tick();
        check("midreset beat1", m_data, 72'h22d);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midreset");
        tick();
        check("midreset no done", done, 0);
        check("midreset no valid", m_valid, 0);
        tick();
        check("midreset still idle", m_valid, 0);
        tmp = '{10'd10, 11'd3, 0, 72'h10a, 72'h10c};
        run_cmd(tmp, 6);
        tick();

        // Back-to-back: second start issued in the done cycle of the first.
        tmp = '{10'd40, 11'd3, 0, 72'h128, 72'h12a};
        run_cmd(tmp, 7);
        tmp = '{10'd600, 11'd5, 0, 72'h358, 72'h35c};
        run_cmd(tmp, 8);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Block-read engine for the `bram_sp` single-port RAM. On a `start` command it walks a contiguous address range, issues reads to the RAM port, absorbs the RAM's one-cycle read latency, and presents the words as a valid/ready stream with a last-beat marker. It sits between a `bram_sp` instance and any streaming consumer, such as a UART or SPI transmitter or a DMA sink.

## Interface
Parameters:
- `data_width`, 72, RAM word and stream data width
- `address_width`, 10, RAM address width; addresses wrap modulo 2^address_width

Ports:
- `clk`, in, 1: the single clock
- `reset`, in, 1: synchronous, active-high
- `start`, in, 1: one-cycle command strobe; ignored while `busy`=1
- `start_addr`, in, address_width: first address, sampled when `start` is accepted
- `length`, in, address_width+1: word count, 0..2^address_width, sampled with `start`
- `busy`, out, 1: high from the cycle after acceptance until `done`
- `done`, out, 1: one-cycle pulse at the end of a command
- `ram_addr`, out, address_width: registered address to the `bram_sp` `addr` port
- `ram_wr`, out, 1: tied 0; the block never writes
- `ram_dout`, in, data_width: `bram_sp` `dout`
- `m_data`, out, data_width: stream data
- `m_valid`, out, 1: stream valid
- `m_ready`, in, 1: stream ready
- `m_last`, out, 1: high with the final beat of a command

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE to RUN on `start` when `length`>0.
  - IDLE on `start` with `length`=0: no state change. `done` pulses on the next cycle, no beats are produced, and `busy` stays 0.
  - RUN to DRAIN when the last read has been issued.
  - DRAIN to IDLE on the handshake of the `m_last` beat. `done` pulses in the following cycle.
- Issue rule: issue a read in a cycle only if (FIFO occupancy + reads in flight − pops this cycle) < 2. The 2-entry output FIFO must never overflow or drop a word.
- Each issued read increments `ram_addr` by 1 modulo 2^address_width. For example, `start_addr`=1022 with `length`=4 reads 1022, 1023, 0, 1.
- A beat transfers when `m_valid` and `m_ready` are both 1. While `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold stable.
- `m_last` is asserted only on beat number `length`.
- Remaining-word counter width is address_width+1, so `length`=2^address_width is legal.
- Reset at any time, including mid-command: the FIFO is emptied, in-flight reads are discarded, and the state returns to IDLE with no `done` pulse.
- Reset value of every output is 0: `busy`, `done`, `ram_addr`, `ram_wr`, `m_data`, `m_valid`, `m_last`.

## Timing
- Cycle 0: `start` is accepted.
- Cycle 1: `ram_addr`=`start_addr` and the first read is issued; `busy`=1.
- Cycle 2: `ram_dout` holds the word and is captured into the FIFO at the end of the cycle.
- Cycle 3: first `m_valid`=1.
- Start-to-first-valid latency is 3 cycles.
- With `m_ready` held at 1, throughput is 1 beat per cycle with no bubbles after the first beat.
- When `m_ready` deasserts, at most 2 words are buffered and issue stalls. When `m_ready` reasserts, beats resume on the next cycle with no lost or duplicated words.
- `done` pulses exactly one cycle after the `m_last` handshake. `busy` falls in the same cycle as `done`.
- `start` may be accepted in the cycle `done` is high.

## Structure
- Package `bram_reader_pkg` holds:
  - the state enum `reader_state_t` (IDLE, RUN, DRAIN);
  - the FIFO depth constant `READER_FIFO_DEPTH`=2.
- Sub-module `reader_fifo2`: a 2-entry synchronous FIFO with push/pop, occupancy count, and registered head outputs. It uses the same synchronous active-high reset.
- The top level contains the FSM, the address and remaining-word counters, the in-flight tracking, and the issue logic.

## Test plan
- Basic stream: preload RAM[i]=i+0x100, `start_addr`=5, `length`=4, `m_ready`=1.
  - Expect beats 0x105..0x108 on cycles 3..6.
  - `m_last` on 0x108; `done` on cycle 7.
- Backpressure: `length`=8 with `m_ready` toggling in a random pattern.
  - Expect all 8 words in order with none lost or duplicated.
  - `m_data` stable during every stall.
  - FIFO occupancy never exceeds 2.
- Wrap and full range:
  - `start_addr`=1022, `length`=4 reads addresses 1022, 1023, 0, 1.
  - `length`=1024 from address 0 yields 1024 beats, with `m_last` only on the last.
- Zero length and ignored start:
  - `length`=0 gives a `done` pulse in the next cycle, no `m_valid`, and `busy` stays 0.
  - A second `start` while `busy`=1 is ignored, and the original command completes unchanged.
- Reset mid-command: assert `reset` after 2 of 6 beats.
  - All outputs read 0 the next cycle, with no `done` pulse.
  - A new command afterwards streams correctly from its own `start_addr`.
- Back-to-back: `start` in the same cycle as `done`.
  - The second command's first beat appears 3 cycles later.
  - `ram_wr` is 0 throughout.
